otl_reg_bank: RTL

//  Memory-mapped register bank that sits directly downstream of the AXI4-Lite slave and

---
 rtl/otl_reg_bank_if.sv | 37 +++
 rtl/otl_reg_bank.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/otl_reg_bank_if.sv
// Memory-side request/response bundle between the AXI4-Lite slave (master modport)
// and the register bank (slave modport).
interface otl_reg_bank_if #(
  parameter int unsigned ADDRW = 32,
  parameter int unsigned DATAW = 32
);
  logic [ADDRW-1:0]   m_wraddr;
  logic [DATAW-1:0]   m_wrdata;
  logic [DATAW/8-1:0] m_wrstrb;
  logic               m_wrvalid;
  logic               m_wrready;
  logic               m_wrdone;
  logic               m_wrerr;
  logic [ADDRW-1:0]   m_rdaddr;
  logic               m_rdvalid;
  logic               m_rdready;
  logic [DATAW-1:0]   m_rddata;
  logic               m_rderr;
  logic               m_rspvalid;
  logic               m_rspready;

  modport master (
    output m_wraddr, m_wrdata, m_wrstrb, m_wrvalid,
    input  m_wrready, m_wrdone, m_wrerr,
    output m_rdaddr, m_rdvalid,
    input  m_rdready, m_rddata, m_rderr, m_rspvalid,
    output m_rspready
  );

  modport slave (
    input  m_wraddr, m_wrdata, m_wrstrb, m_wrvalid,
    output m_wrready, m_wrdone, m_wrerr,
    input  m_rdaddr, m_rdvalid,
    output m_rdready, m_rddata, m_rderr, m_rspvalid,
    input  m_rspready
  );
endinterface

// File: rtl/otl_reg_bank.sv
// Register bank behind the AXI4-Lite slave: NREGS byte-strobed words, read-only
// VERSION at index 0, one-deep registered read response with decode-error flags.
module otl_reg_bank #(
  parameter int unsigned      ADDRW   = 32,
  parameter int unsigned      DATAW   = 32,
  parameter int unsigned      NREGS   = 16,
  parameter logic [DATAW-1:0] VERSION = 32'h0001_0000
) (
  input logic           s_axi_aclk,
  input logic           s_axi_areset,
  otl_reg_bank_if.slave bus
);

  localparam int unsigned NBYTES = DATAW / 8;
  localparam int unsigned LSB    = $clog2(NBYTES);
  localparam int unsigned IDXW   = $clog2(NREGS);
  localparam logic [IDXW:0] NREGS_W = (IDXW + 1)'(NREGS);

  typedef enum logic {
    RD_EMPTY,
    RD_FULL
  } rd_state_t;

  // Word 0 is the constant VERSION, so only indices 1..NREGS-1 need storage.
  logic [DATAW-1:0] regs [1:NREGS-1];

  logic             wrready_q;
  logic             wrdone_q;
  logic             wrerr_q;

  rd_state_t        rd_state;
  logic             rspvalid_q;
  logic [DATAW-1:0] rddata_q;
  logic             rderr_q;

  logic [IDXW-1:0]  wr_idx;
  logic [IDXW-1:0]  rd_idx;
  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_hit;
  logic             wr_acc;
  logic             rd_acc;
  logic             rdready;
  logic [DATAW-1:0] rd_word;
  logic             rd_word_err;
  logic             unused_addr_bits;

  // Byte-offset bits below LSB carry no meaning for word access.
  assign unused_addr_bits = ^{bus.m_wraddr, bus.m_rdaddr};

  function automatic logic idx_in_range(input logic [ADDRW-1:0] a);
    logic [IDXW-1:0] i;
    i = a[LSB +: IDXW];
    return (a[ADDRW-1:LSB+IDXW] == '0) && ({1'b0, i} < NREGS_W);
  endfunction

  assign wr_idx      = bus.m_wraddr[LSB +: IDXW];
  assign rd_idx      = bus.m_rdaddr[LSB +: IDXW];
  assign wr_in_range = idx_in_range(bus.m_wraddr);
  assign rd_in_range = idx_in_range(bus.m_rdaddr);
  assign wr_hit      = wr_in_range && (wr_idx != '0);

  assign wr_acc  = bus.m_wrvalid && wrready_q;
  assign rdready = !rspvalid_q || bus.m_rspready;
  assign rd_acc  = bus.m_rdvalid && rdready;

  always_comb begin
    rd_word     = '0;
    rd_word_err = 1'b1;
    if (rd_in_range) begin
      rd_word_err = 1'b0;
      if (rd_idx == '0) begin
        rd_word = VERSION;
      end else begin
        rd_word = regs[rd_idx];
      end
    end
  end

  // Write channel: storage and the one-cycle completion pulse.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wrready_q <= 1'b0;
      wrdone_q  <= 1'b0;
      wrerr_q   <= 1'b0;
    end else begin
      wrready_q <= 1'b1;
      wrdone_q  <= wr_acc;
      wrerr_q   <= wr_acc && !wr_hit;
      if (wr_acc && wr_hit) begin
        for (int unsigned b = 0; b < NBYTES; b++) begin
          if (bus.m_wrstrb[b]) begin
            regs[wr_idx][8*b +: 8] <= bus.m_wrdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read response FSM; rd_word samples storage before any same-edge write lands.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_state   <= RD_EMPTY;
      rspvalid_q <= 1'b0;
      rddata_q   <= '0;
      rderr_q    <= 1'b0;
    end else begin
      case (rd_state)
        RD_EMPTY: begin
          if (rd_acc) begin
            rd_state   <= RD_FULL;
            rspvalid_q <= 1'b1;
            rddata_q   <= rd_word;
            rderr_q    <= rd_word_err;
          end
        end
        RD_FULL: begin
          if (bus.m_rspready) begin
            if (rd_acc) begin
              rddata_q <= rd_word;
              rderr_q  <= rd_word_err;
            end else begin
              rd_state   <= RD_EMPTY;
              rspvalid_q <= 1'b0;
            end
          end
        end
        default: begin
          rd_state   <= RD_EMPTY;
          rspvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.m_wrready  = wrready_q;
  assign bus.m_wrdone   = wrdone_q;
  assign bus.m_wrerr    = wrerr_q;
  assign bus.m_rdready  = rdready;
  assign bus.m_rddata   = rddata_q;
  assign bus.m_rderr    = rderr_q;
  assign bus.m_rspvalid = rspvalid_q;

endmodule
